// File: rtl/mprjram_arbiter.sv
// rtl/mprjram_arbiter.sv - round-robin Wishbone/DMA arbiter and latency sequencer for the mprjram BRAM
// Optional statistics counters are built when MPRJRAM_ARB_STATS_EN is defined.
module mprjram_arbiter #(
  parameter int         DELAY   = 10,
  parameter int         ADDR_W  = 12,
  parameter logic [7:0] BASE_HI = 8'h38
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [31:0]       dma_wdata,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [31:0]       dma_rdata,
  output logic              bram_en,
  output logic [3:0]        bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [31:0]       bram_wdata,
  input  logic [31:0]       bram_rdata
`ifdef MPRJRAM_ARB_STATS_EN
  ,
  output logic [15:0]       stat_wb_cnt,
  output logic [15:0]       stat_dma_cnt,
  output logic [15:0]       stat_conflict_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

  state_t            state, state_d;
  logic              last_dma, last_dma_d;
  logic              owner_dma, owner_dma_d;
  logic              is_wr, is_wr_d;
  logic [3:0]        cnt, cnt_d;
  logic              wb_req, grant_wb, grant_dma;

  logic              wbs_ack_d, dma_gnt_d, dma_rvalid_d, bram_en_d;
  logic [3:0]        bram_we_d;
  logic [ADDR_W-1:0] bram_addr_d;
  logic [31:0]       bram_wdata_d, wbs_dat_d, dma_rdata_d;

  logic              unused_adr_bits;

  assign wb_req          = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:24] == BASE_HI);
  assign unused_adr_bits = ^{wbs_adr_i[23:ADDR_W+2], wbs_adr_i[1:0]};

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state      <= IDLE;
      last_dma   <= 1'b1;
      owner_dma  <= 1'b0;
      is_wr      <= 1'b0;
      cnt        <= 4'd0;
      wbs_ack_o  <= 1'b0;
      wbs_dat_o  <= 32'h0;
      dma_gnt    <= 1'b0;
      dma_rvalid <= 1'b0;
      dma_rdata  <= 32'h0;
      bram_en    <= 1'b0;
      bram_we    <= 4'h0;
      bram_addr  <= '0;
      bram_wdata <= 32'h0;
    end else begin
      state      <= state_d;
      last_dma   <= last_dma_d;
      owner_dma  <= owner_dma_d;
      is_wr      <= is_wr_d;
      cnt        <= cnt_d;
      wbs_ack_o  <= wbs_ack_d;
      wbs_dat_o  <= wbs_dat_d;
      dma_gnt    <= dma_gnt_d;
      dma_rvalid <= dma_rvalid_d;
      dma_rdata  <= dma_rdata_d;
      bram_en    <= bram_en_d;
      bram_we    <= bram_we_d;
      bram_addr  <= bram_addr_d;
      bram_wdata <= bram_wdata_d;
    end
  end

  always_comb begin
    state_d     = state;
    last_dma_d  = last_dma;
    owner_dma_d = owner_dma;
    is_wr_d     = is_wr;
    cnt_d       = cnt;
    grant_wb    = 1'b0;
    grant_dma   = 1'b0;
    case (state)
      IDLE: begin
        if (wb_req && (!dma_req || last_dma)) grant_wb = 1'b1;
        else if (dma_req)                     grant_dma = 1'b1;
        if (grant_wb || grant_dma) begin
          state_d     = ISSUE;
          owner_dma_d = grant_dma;
          last_dma_d  = grant_dma;
          is_wr_d     = grant_dma ? dma_we : wbs_we_i;
        end
      end
      // Writes take one WAIT pass with a zero count, landing the ack two cycles after the grant.
      ISSUE: begin
        state_d = WAIT;
        cnt_d   = is_wr ? 4'd0 : 4'(DELAY - 1);
      end
      WAIT: begin
        if (cnt == 4'd0) state_d = ACK;
        else             cnt_d   = cnt - 4'd1;
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bram_en_d    = 1'b0;
    bram_we_d    = 4'h0;
    bram_addr_d  = bram_addr;
    bram_wdata_d = bram_wdata;
    dma_gnt_d    = 1'b0;
    wbs_ack_d    = 1'b0;
    wbs_dat_d    = wbs_dat_o;
    dma_rvalid_d = 1'b0;
    dma_rdata_d  = dma_rdata;
    if (grant_wb) begin
      bram_en_d    = 1'b1;
      bram_addr_d  = wbs_adr_i[ADDR_W+1:2];
      bram_wdata_d = wbs_dat_i;
      bram_we_d    = wbs_we_i ? wbs_sel_i : 4'h0;
    end else if (grant_dma) begin
      bram_en_d    = 1'b1;
      bram_addr_d  = dma_addr;
      bram_wdata_d = dma_wdata;
      bram_we_d    = dma_we ? 4'hF : 4'h0;
      dma_gnt_d    = 1'b1;
    end
    if (state == WAIT && cnt == 4'd0) begin
      if (!owner_dma) begin
        wbs_ack_d = 1'b1;
        wbs_dat_d = is_wr ? 32'h0 : bram_rdata;
      end else if (!is_wr) begin
        dma_rvalid_d = 1'b1;
        dma_rdata_d  = bram_rdata;
      end
    end
  end

`ifdef MPRJRAM_ARB_STATS_EN
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      stat_wb_cnt       <= 16'h0;
      stat_dma_cnt      <= 16'h0;
      stat_conflict_cnt <= 16'h0;
    end else if (state == IDLE) begin
      if (grant_wb && stat_wb_cnt != 16'hFFFF)
        stat_wb_cnt <= stat_wb_cnt + 16'h1;
      if (grant_dma && stat_dma_cnt != 16'hFFFF)
        stat_dma_cnt <= stat_dma_cnt + 16'h1;
      if (wb_req && dma_req && stat_conflict_cnt != 16'hFFFF)
        stat_conflict_cnt <= stat_conflict_cnt + 16'h1;
    end
  end
`endif

endmodule
